// File: rtl/geofence_seq_ctrl.sv
// Phase sequencer for the geofence datapath: READ..COMP one-hot commands with a
// one-cycle counter-reset GAP between phases. Optional watchdog: GEOFENCE_CTRL_WDT_EN.
module geofence_seq_ctrl #(
    parameter int CMD_FLAG_W = 8,
    parameter int INT_FLAG_W = 8,
    parameter int WDT_LIMIT  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [INT_FLAG_W-1:0] int_flags,
    input  logic                  task_done,
    output logic [CMD_FLAG_W-1:0] cmd_flags,
    output logic                  cnt_rst,
    output logic                  busy,
    output logic [3:0]            phase,
    output logic                  wdt_err
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_GAP      = 4'd1,
        S_READ     = 4'd2,
        S_VECT     = 4'd3,
        S_CROS     = 4'd4,
        S_SORT     = 4'd5,
        S_EDGE     = 4'd6,
        S_AREA     = 4'd7,
        S_SUM_AREA = 4'd8,
        S_COMP     = 4'd9
    } state_t;

    state_t                  state_q, state_d;
    state_t                  nxt_q, nxt_d;
    logic [CMD_FLAG_W-1:0]   cmd_d;
    logic [2:0]              cur_idx;
    logic                    in_phase;
    logic                    cur_flag;

    // Phase states map onto flag bits 0..7 by subtracting the READ encoding.
    assign cur_idx  = 3'(state_q - 4'd2);
    assign in_phase = (state_q >= S_READ);
    assign cur_flag = int_flags[cur_idx];
    assign phase    = state_q;

`ifdef GEOFENCE_CTRL_WDT_EN
    logic [6:0] wdt_cnt;
    logic       wdt_expire;
    logic       abort_d;
    logic       wdt_err_q;

    assign wdt_expire = in_phase && (wdt_cnt == 7'(WDT_LIMIT - 1));
    assign wdt_err    = wdt_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdt_cnt   <= '0;
            wdt_err_q <= 1'b0;
        end else begin
            wdt_cnt   <= (in_phase && state_d == state_q) ? wdt_cnt + 7'd1 : '0;
            wdt_err_q <= abort_d;
        end
    end
`else
    logic wdt_unused;
    assign wdt_unused = (WDT_LIMIT == 0);
    assign wdt_err    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        nxt_d   = nxt_q;
        cmd_d   = '0;
`ifdef GEOFENCE_CTRL_WDT_EN
        abort_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    nxt_d   = S_READ;
                    state_d = S_GAP;
                end
            end
            S_GAP: state_d = nxt_q;
            S_READ, S_VECT, S_CROS, S_SORT, S_EDGE, S_AREA, S_SUM_AREA: begin
                if (cur_flag) begin
                    nxt_d   = state_t'(state_q + 4'd1);
                    state_d = S_GAP;
                end
`ifdef GEOFENCE_CTRL_WDT_EN
                else if (wdt_expire) begin
                    nxt_d   = S_IDLE;
                    state_d = S_GAP;
                    abort_d = 1'b1;
                end
`endif
            end
            S_COMP: begin
                if (task_done || cur_flag) begin
                    nxt_d   = enable ? S_READ : S_IDLE;
                    state_d = S_GAP;
                end
`ifdef GEOFENCE_CTRL_WDT_EN
                else if (wdt_expire) begin
                    nxt_d   = S_IDLE;
                    state_d = S_GAP;
                    abort_d = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered from the next state so they align with it.
        if (state_d >= S_READ)
            cmd_d[3'(state_d - 4'd2)] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            nxt_q     <= S_READ;
            cmd_flags <= '0;
            cnt_rst   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            nxt_q     <= nxt_d;
            cmd_flags <= cmd_d;
            cnt_rst   <= (state_d == S_GAP);
            busy      <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_geofence_seq_ctrl.sv
// Directed bench for geofence_seq_ctrl: phase walk, flag filtering, back-to-back,
// mid-task reset, and stall / watchdog behaviour depending on the build.
module tb_geofence_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] int_flags;
    logic       task_done;
    logic [7:0] cmd_flags;
    logic       cnt_rst;
    logic       busy;
    logic [3:0] phase;
    logic       wdt_err;

    int errors = 0;
    int checks = 0;
    int dur[8] = '{7, 7, 26, 20, 8, 8, 8, 7};

    logic [14:0] obs;
    assign obs = {cmd_flags, cnt_rst, busy, phase, wdt_err};

    geofence_seq_ctrl #(.CMD_FLAG_W(8), .INT_FLAG_W(8), .WDT_LIMIT(64)) dut (
        .clk(clk), .reset(reset), .enable(enable), .int_flags(int_flags),
        .task_done(task_done), .cmd_flags(cmd_flags), .cnt_rst(cnt_rst),
        .busy(busy), .phase(phase), .wdt_err(wdt_err)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] ev(input logic [7:0] c, input logic cr, input logic b,
                                       input logic [3:0] ph, input logic we);
        return {c, cr, b, ph, we};
    endfunction

    // Enter at the negedge of the phase's first cycle; leave at the negedge after its GAP.
    task automatic run_phase(input int b, input int d);
        logic [7:0] oh;
        oh = 8'(1 << b);
        checks++;
        if (obs !== ev(oh, 1'b0, 1'b1, 4'(b + 2), 1'b0)) begin
            errors++;
            $display("FAIL phase%0d_entry got=%h exp=%h", b, obs, ev(oh, 1'b0, 1'b1, 4'(b + 2), 1'b0));
        end
        repeat (d - 1) @(negedge clk);
        if (b == 7) task_done = 1'b1;
        else        int_flags = oh;
        @(negedge clk);
        task_done = 1'b0;
        int_flags = 8'h00;
        checks++;
        if (obs !== ev(8'h00, 1'b1, 1'b1, 4'd1, 1'b0)) begin
            errors++;
            $display("FAIL phase%0d_gap got=%h exp=%h", b, obs, ev(8'h00, 1'b1, 1'b1, 4'd1, 1'b0));
        end
        @(negedge clk);
    endtask

    task automatic start_task();
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== ev(8'h00, 1'b1, 1'b1, 4'd1, 1'b0)) begin
            errors++;
            $display("FAIL start_gap got=%h exp=%h", obs, ev(8'h00, 1'b1, 1'b1, 4'd1, 1'b0));
        end
        @(negedge clk);
    endtask

    task automatic expect_idle(input string name);
        checks++;
        if (obs !== ev(8'h00, 1'b0, 1'b0, 4'd0, 1'b0)) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, obs, ev(8'h00, 1'b0, 1'b0, 4'd0, 1'b0));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; int_flags = 8'h00; task_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            expect_idle("reset_idle");
        end
    endtask

    task automatic test_full_task();
        start_task();
        for (int b = 0; b < 8; b++) run_phase(b, dur[b]);
    endtask

    // Continues straight from the previous task's COMP; enable drops mid-task.
    task automatic test_back_to_back();
        enable = 1'b0;
        for (int b = 0; b < 8; b++) run_phase(b, dur[b]);
        expect_idle("b2b_idle");
        @(negedge clk);
        expect_idle("b2b_idle_hold");
    endtask

    task automatic test_ignore_other();
        start_task();
        enable = 1'b0;
        run_phase(0, dur[0]);
        run_phase(1, dur[1]);
        int_flags = 8'h01;
        @(negedge clk);
        int_flags = 8'h00;
        repeat (4) begin
            checks++;
            if (obs !== ev(8'h04, 1'b0, 1'b1, 4'd4, 1'b0)) begin
                errors++;
                $display("FAIL cros_hold got=%h exp=%h", obs, ev(8'h04, 1'b0, 1'b1, 4'd4, 1'b0));
            end
            @(negedge clk);
        end
        int_flags = 8'h04;
        @(negedge clk);
        int_flags = 8'h00;
        checks++;
        if (obs !== ev(8'h00, 1'b1, 1'b1, 4'd1, 1'b0)) begin
            errors++;
            $display("FAIL cros_gap got=%h exp=%h", obs, ev(8'h00, 1'b1, 1'b1, 4'd1, 1'b0));
        end
        @(negedge clk);
        int_flags = 8'hF7;
        repeat (3) begin
            checks++;
            if (obs !== ev(8'h08, 1'b0, 1'b1, 4'd5, 1'b0)) begin
                errors++;
                $display("FAIL sort_multi_hold got=%h exp=%h", obs, ev(8'h08, 1'b0, 1'b1, 4'd5, 1'b0));
            end
            @(negedge clk);
        end
        int_flags = 8'hFF;
        @(negedge clk);
        int_flags = 8'h00;
        checks++;
        if (obs !== ev(8'h00, 1'b1, 1'b1, 4'd1, 1'b0)) begin
            errors++;
            $display("FAIL sort_multi_gap got=%h exp=%h", obs, ev(8'h00, 1'b1, 1'b1, 4'd1, 1'b0));
        end
        @(negedge clk);
        for (int b = 4; b < 8; b++) run_phase(b, dur[b]);
        expect_idle("ignore_idle");
    endtask

    task automatic test_reset_mid();
        start_task();
        enable = 1'b0;
        for (int b = 0; b < 5; b++) run_phase(b, dur[b]);
        #2 reset = 1'b1;
        #1;
        expect_idle("reset_mid_async");
        enable = 1'b1;
        @(negedge clk);
        expect_idle("reset_mid_held");
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== ev(8'h00, 1'b1, 1'b1, 4'd1, 1'b0)) begin
            errors++;
            $display("FAIL restart_gap got=%h exp=%h", obs, ev(8'h00, 1'b1, 1'b1, 4'd1, 1'b0));
        end
        @(negedge clk);
        enable = 1'b0;
        for (int b = 0; b < 8; b++) run_phase(b, dur[b]);
        expect_idle("restart_idle");
    endtask

`ifdef GEOFENCE_CTRL_WDT_EN
    task automatic test_watchdog();
        start_task();
        enable = 1'b0;
        for (int b = 0; b < 3; b++) run_phase(b, dur[b]);
        repeat (64) @(negedge clk);
        checks++;
        if (obs !== ev(8'h00, 1'b1, 1'b1, 4'd1, 1'b1)) begin
            errors++;
            $display("FAIL wdt_abort got=%h exp=%h", obs, ev(8'h00, 1'b1, 1'b1, 4'd1, 1'b1));
        end
        @(negedge clk);
        expect_idle("wdt_idle");
        start_task();
        enable = 1'b0;
        for (int b = 0; b < 3; b++) run_phase(b, dur[b]);
        repeat (63) @(negedge clk);
        int_flags = 8'h08;
        @(negedge clk);
        int_flags = 8'h00;
        checks++;
        if (obs !== ev(8'h00, 1'b1, 1'b1, 4'd1, 1'b0)) begin
            errors++;
            $display("FAIL wdt_flag_wins got=%h exp=%h", obs, ev(8'h00, 1'b1, 1'b1, 4'd1, 1'b0));
        end
        @(negedge clk);
        for (int b = 4; b < 8; b++) run_phase(b, dur[b]);
        expect_idle("wdt_edge_idle");
    endtask
`else
    task automatic test_stall();
        start_task();
        enable = 1'b0;
        for (int b = 0; b < 3; b++) run_phase(b, dur[b]);
        repeat (80) @(negedge clk);
        checks++;
        if (obs !== ev(8'h08, 1'b0, 1'b1, 4'd5, 1'b0)) begin
            errors++;
            $display("FAIL stall_hold got=%h exp=%h", obs, ev(8'h08, 1'b0, 1'b1, 4'd5, 1'b0));
        end
        run_phase(3, 1);
        for (int b = 4; b < 8; b++) run_phase(b, dur[b]);
        expect_idle("stall_idle");
    endtask
`endif

    initial begin
        test_reset();
        test_full_task();
        test_back_to_back();
        test_ignore_other();
        test_reset_mid();
`ifdef GEOFENCE_CTRL_WDT_EN
        test_watchdog();
`else
        test_stall();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/geofence_seq_ctrl.md
# geofence_seq_ctrl

Phase sequencer for the geofence datapath. It issues one-hot phase commands in a fixed order: READ, VECT, CROS, SORT, EDGE, AREA, SUM_AREA, COMP. It pulses the datapath's shared-counter reset between phases and advances on each phase-complete flag. It sits between the top-level wrapper and the datapath, and loops back to READ for back-to-back tasks while `enable` is high.

## Interface
- `CMD_FLAG_W`, default 8: command vector width. Bit map: READ 0, VECT 1, CROS 2, SORT 3, EDGE 4, AREA 5, SUM_AREA 6, COMP 7.
- `INT_FLAG_W`, default 8: completion flag width, same bit map as `CMD_FLAG_W`.
- `WDT_LIMIT`, default 64: cycles allowed per phase before abort (watchdog builds only).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  permits task start; sampled in IDLE and at end of COMP.
- `int_flags`  in  INT_FLAG_W  datapath phase-complete flags, registered by datapath.
- `task_done`  in  1  datapath end-of-task pulse.
- `cmd_flags`  out  CMD_FLAG_W  registered, one-hot or zero.
- `cnt_rst`  out  1  registered; resets datapath shared counter.
- `busy`  out  1  high in every state except IDLE.
- `phase`  out  4  current state encoding (debug).
- `wdt_err`  out  1  one-cycle abort pulse; constant 0 when the watchdog is not compiled in.

## Operation
- State encodings: IDLE 0, GAP 1, READ 2, VECT 3, CROS 4, SORT 5, EDGE 6, AREA 7, SUM_AREA 8, COMP 9.
- A `nxt_phase` register holds the phase to enter after GAP.
- IDLE:
  - `cmd_flags`=0, `cnt_rst`=0.
  - When `enable`=1: `nxt_phase`←READ, go to GAP.
- GAP (exactly one cycle):
  - `cmd_flags`=0, `cnt_rst`=1.
  - Next state = `nxt_phase`.
- Phase state P (READ..SUM_AREA):
  - `cmd_flags`=onehot(P), `cnt_rst`=0.
  - When `int_flags[P]`=1: `nxt_phase`←P+1, go to GAP.
  - Flags of all other phases are ignored.
- COMP:
  - `cmd_flags`=onehot(COMP).
  - Exit when `task_done`=1 or `int_flags[COMP]`=1.
  - On exit, if `enable`=1: `nxt_phase`←READ, go to GAP. Otherwise go to GAP with `nxt_phase`←IDLE.
- `enable` deasserted mid-task does not abort the task.
- Multiple bits set in `int_flags` simultaneously: only the current phase's bit counts.

## Timing
- All outputs are registered, driven from the state register.
- Reset values: `cmd_flags`=0, `cnt_rst`=0, `busy`=0, `phase`=0, `wdt_err`=0, `nxt_phase`=READ, watchdog count=0.
- Start latency: `enable` high at edge N → GAP (`cnt_rst`=1) during cycle N+1 → `cmd_flags[0]`=1 from N+2.
- Phase change: current flag sampled high at edge M → `cmd_flags`=0 and `cnt_rst`=1 in cycle M+1 → next command from M+2. Every phase boundary costs 2 cycles, including the datapath's extra counted cycle; the datapath guards its counter ranges.
- Full task with datapath nominal durations: READ 7, VECT 7, CROS 26, SORT ≤30, EDGE 8, AREA 8, SUM 8, COMP 7 cycles, plus 8 GAPs.
- Reset asserted mid-task: immediate return to IDLE, all outputs cleared asynchronously.

## Configuration
- Macro: `GEOFENCE_CTRL_WDT_EN`.
- Defined:
  - A 7-bit per-phase cycle counter clears on phase entry and increments each cycle in READ..COMP.
  - On reaching `WDT_LIMIT` with the current flag low: next cycle `cmd_flags`=0, `cnt_rst`=1, `wdt_err`=1, state GAP with `nxt_phase`←IDLE.
  - If the flag and expiry occur in the same cycle, the flag wins and there is no error.
- Undefined: no counter, `wdt_err` tied 0, a stalled phase waits indefinitely.

## Test plan
- Reset release, `enable`=0 for 10 cycles → `cmd_flags`=0, `busy`=0, `phase`=0 throughout.
- `enable`=1 at cycle 0, model datapath with nominal durations → `cmd_flags` walks 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x80. Each is preceded by exactly one cycle with `cmd_flags`=0 and `cnt_rst`=1.
- In CROS, pulse `int_flags`=0x01 (READ bit), then 0x04 five cycles later → stays in CROS until the 0x04 pulse, then GAP, then SORT (0x08).
- `enable` held high, `task_done` during COMP → GAP then `cmd_flags`=0x01 again. With `enable`=0 at that point instead → GAP then IDLE, `busy`=0.
- Assert `reset` during AREA → same cycle `cmd_flags`=0, `phase`=0. After release with `enable`=1 → restart at READ.
- Watchdog build, `WDT_LIMIT`=64, withhold the SORT flag → after 64 SORT cycles `wdt_err`=1 for one cycle, then IDLE. Flag arriving on cycle 64 → no error, advance to EDGE.
